// File: rtl/fanout_fork_buffer.sv
// Single-entry broadcast buffer: holds one upstream token and offers it to every
// active downstream branch, tracking per-branch acceptance until all have taken it.
module fanout_fork_buffer #(
    parameter int unsigned NUM_OUT    = 9,
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_OUT-1:0]    out_en,
    input  logic [NUM_OUT-1:0]    out_sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [CNT_WIDTH-1:0]  done_cnt
);

    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_OUT-1:0]    done_q, done_d;
    logic [CNT_WIDTH-1:0]  cnt_q,  cnt_d;

    logic [NUM_OUT-1:0]    active;
    logic [NUM_OUT-1:0]    fire;
    logic                  all_done;
    logic                  accept;

    // Handshake terms; a branch that is inactive or already served counts as complete.
    always_comb begin
        active    = out_en & out_sel;
        out_valid = {NUM_OUT{full_q}} & active & ~done_q;
        fire      = out_valid & out_ready;
        all_done  = &(~active | done_q | fire);
        in_ready  = ~flush & (~full_q | all_done);
        accept    = in_valid & in_ready;
        out_data  = data_q;
        done_cnt  = cnt_q;
    end

    // Next-state: flush, then refill (possibly retiring the held token), then drain, then collect fires.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        done_d = done_q;
        cnt_d  = cnt_q;
        if (flush) begin
            full_d = 1'b0;
            done_d = '0;
            cnt_d  = '0;
        end else if (accept) begin
            data_d = in_data;
            full_d = 1'b1;
            done_d = '0;
            if (full_q) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end else if (full_q && all_done) begin
            full_d = 1'b0;
            done_d = '0;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
        end else begin
            done_d = done_q | fire;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
            done_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
